// File: rtl/btn_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : btn_arb_pkg
//  Purpose  : Shared types and the round-robin pick function used by the
//             button event arbiter and its picker sub-module.
//  Contents : N_SRC_MAX     largest supported source count
//             IDX_MAX_W     index width for N_SRC_MAX sources
//             pick_t        {found, idx} result of a round-robin search
//             out_state_t   output-stage state (EMPTY / HOLD)
//             rr_pick()     first set pending bit at or after ptr, mod n
//  Revision : 1.0  initial release
// ============================================================================
package btn_arb_pkg;

   localparam int N_SRC_MAX = 16;
   localparam int IDX_MAX_W = 4;

   typedef struct packed {
      logic                 found;
      logic [IDX_MAX_W-1:0] idx;
   } pick_t;

   typedef enum logic [0:0] {
      ST_EMPTY = 1'b0,
      ST_HOLD  = 1'b1
   } out_state_t;

   // Searches ptr, ptr+1, ... wrapping at n. ptr is always < n and the
   // loop index k < n, so a single subtraction is enough to wrap.
   function automatic pick_t rr_pick(input logic [N_SRC_MAX-1:0] pending,
                                     input logic [IDX_MAX_W-1:0] ptr,
                                     input int                   n);
      pick_t r;
      int    j;
      r = '0;
      for (int k = 0; k < N_SRC_MAX; k++) begin
         if (k < n) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if (!r.found && pending[j]) begin
               r.found = 1'b1;
               r.idx   = IDX_MAX_W'(j);
            end
         end
      end
      return r;
   endfunction

endpackage : btn_arb_pkg
`default_nettype wire

// File: rtl/button_event_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module   : rr_picker
//  Purpose  : Combinational round-robin selector: rotates the pending vector
//             to start at i_ptr and returns the first set source.
//  Ports    : i_pending  [N_SRC]  pending request bits
//             i_ptr      [IDX_W]  highest-priority source this cycle
//             o_found             at least one pending bit set
//             o_idx      [IDX_W]  index of the selected source
//  Revision : 1.0  initial release
// ============================================================================
module rr_picker
   import btn_arb_pkg::*;
#(
   parameter int N_SRC = 4,
   localparam int IDX_W = $clog2(N_SRC)
) (
   input  logic [N_SRC-1:0] i_pending,
   input  logic [IDX_W-1:0] i_ptr,
   output logic             o_found,
   output logic [IDX_W-1:0] o_idx
);

   logic [N_SRC_MAX-1:0] w_pending_ext;
   logic [IDX_MAX_W-1:0] w_ptr_ext;
   pick_t                w_pick;
   logic                 w_unused_idx_hi;

   // Widen to the package's fixed search width; unused upper sources are 0.
   always_comb begin
      w_pending_ext              = '0;
      w_pending_ext[N_SRC-1:0]   = i_pending;
      w_ptr_ext                  = '0;
      w_ptr_ext[IDX_W-1:0]       = i_ptr;
   end

   assign w_pick          = rr_pick(w_pending_ext, w_ptr_ext, N_SRC);
   assign o_found         = w_pick.found;
   assign o_idx           = w_pick.idx[IDX_W-1:0];
   // Upper index bits are always zero for N_SRC below the maximum.
   assign w_unused_idx_hi = &{1'b0, w_pick.idx};

endmodule : rr_picker
`default_nettype wire

// File: rtl/button_event_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : button_event_arbiter
//  Purpose  : Serialises one-cycle press pulses from N_SRC debouncers into a
//             single valid/ready event stream carrying the source index.
//             Round-robin among simultaneous presses; a press on a source
//             that is already pending is dropped and flagged.
//  Config   : ARB_DROP_CNT_EN  adds the saturating drop_cnt output.
//  Ports    : clk        system clock
//             rst        synchronous active-high reset
//             pulse      [N_SRC]  press pulses, bit i = source i
//             evt_valid           event available
//             evt_idx    [IDX_W]  source index of presented event
//             evt_ready           consumer accept
//             overflow            sticky drop flag
//             ovf_clr             clears overflow / drop_cnt
//             drop_cnt   [DROP_W] saturating drop count (ARB_DROP_CNT_EN)
//  Revision : 1.0  initial release
// ============================================================================
module button_event_arbiter
   import btn_arb_pkg::*;
#(
   parameter int N_SRC  = 4,
   parameter int DROP_W = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_SRC-1:0]         pulse,
   output logic                     evt_valid,
   output logic [$clog2(N_SRC)-1:0] evt_idx,
   input  logic                     evt_ready,
   output logic                     overflow,
`ifdef ARB_DROP_CNT_EN
   output logic [DROP_W-1:0]        drop_cnt,
`endif
   input  logic                     ovf_clr
);

   localparam int IDX_W = $clog2(N_SRC);

   out_state_t       r_state;
   logic [N_SRC-1:0] r_pending;
   logic [IDX_W-1:0] r_evt_idx;
   logic [IDX_W-1:0] r_rr_ptr;
   logic             r_overflow;

   logic             w_found;
   logic [IDX_W-1:0] w_win;
   logic             w_load;
   logic [N_SRC-1:0] w_win_mask;
   logic [N_SRC-1:0] w_drop;
   logic [IDX_W-1:0] w_ptr_next;

   rr_picker #(
      .N_SRC     (N_SRC)
   ) u_picker (
      .i_pending (r_pending),
      .i_ptr     (r_rr_ptr),
      .o_found   (w_found),
      .o_idx     (w_win)
   );

   // The output register can take a new event when empty or being drained.
   assign w_load     = ((r_state == ST_EMPTY) || evt_ready) && w_found;
   assign w_win_mask = w_load ? (N_SRC'(1) << w_win) : '0;
   // A pulse on the source being loaded this edge is a fresh press, not a drop.
   assign w_drop     = pulse & r_pending & ~w_win_mask;
   assign w_ptr_next = (w_win == IDX_W'(N_SRC - 1)) ? '0 : w_win + 1'b1;

   // Output stage: EMPTY presents nothing, HOLD presents r_evt_idx.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= ST_EMPTY;
         r_evt_idx <= '0;
         r_rr_ptr  <= '0;
      end else begin
         case (r_state)
            ST_EMPTY: begin
               if (w_load) begin
                  r_state   <= ST_HOLD;
                  r_evt_idx <= w_win;
                  r_rr_ptr  <= w_ptr_next;
               end
            end
            ST_HOLD: begin
               if (w_load) begin
                  r_evt_idx <= w_win;
                  r_rr_ptr  <= w_ptr_next;
               end else if (evt_ready) begin
                  r_state   <= ST_EMPTY;
               end
            end
            default: r_state <= ST_EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending <= '0;
      end else begin
         r_pending <= (r_pending & ~w_win_mask) | pulse;
      end
   end

   // A drop on the same edge as a clear leaves the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (|w_drop) begin
         r_overflow <= 1'b1;
      end else if (ovf_clr) begin
         r_overflow <= 1'b0;
      end
   end

   assign evt_valid = (r_state == ST_HOLD);
   assign evt_idx   = r_evt_idx;
   assign overflow  = r_overflow;

`ifdef ARB_DROP_CNT_EN
   localparam int SUM_W = DROP_W + 5;

   logic [DROP_W-1:0] r_drop_cnt;
   logic [4:0]        w_drop_num;
   logic [SUM_W-1:0]  w_drop_sum;

   // Each dropping source counts individually.
   always_comb begin
      w_drop_num = '0;
      for (int i = 0; i < N_SRC; i++) begin
         w_drop_num = w_drop_num + 5'(w_drop[i]);
      end
   end

   // Clear restarts from zero but still counts drops on the same edge.
   assign w_drop_sum = (ovf_clr ? '0 : SUM_W'(r_drop_cnt)) + SUM_W'(w_drop_num);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_drop_cnt <= '0;
      end else if (w_drop_sum > SUM_W'({DROP_W{1'b1}})) begin
         r_drop_cnt <= '1;
      end else begin
         r_drop_cnt <= w_drop_sum[DROP_W-1:0];
      end
   end

   assign drop_cnt = r_drop_cnt;
`else
   logic [DROP_W-1:0] w_unused_drop_cnt;
   assign w_unused_drop_cnt = '0;
`endif

endmodule : button_event_arbiter
`default_nettype wire
